// File: rtl/pattern_serializer.sv
// Serial pattern generator: latches a word and frame settings on start, then
// shifts out len bits, each held for div+1 clocks, optionally repeating.
module pattern_serializer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int DIV_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  length,
  input  logic [DIV_W-1:0]  divider,
  input  logic              msb_first,
  input  logic              repeat_mode,
  input  logic              start,
  input  logic              stop,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bit_index
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              msb_q, msb_d;
  logic              rpt_q, rpt_d;
  logic [DIV_W-1:0]  per_cnt_q, per_cnt_d;
  logic [LEN_W-1:0]  bit_idx_q, bit_idx_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  sel;
  logic              accept;
  logic              bit_end;
  logic              last_cycle;

  assign len_clamped = (length > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : length;
  assign accept      = (state_q == ST_IDLE) && start && !stop && (length != '0);
  assign bit_end     = (per_cnt_q == div_q);
  assign last_cycle  = bit_end && (bit_idx_q == (len_q - LEN_W'(1)));

  // Bit k of the frame maps to data[k] or data[len-1-k].
  assign sel = msb_q ? (len_q - LEN_W'(1) - bit_idx_q) : bit_idx_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    div_d     = div_q;
    msb_d     = msb_q;
    rpt_d     = rpt_q;
    per_cnt_d = per_cnt_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d   = ST_SHIFT;
        data_d    = data;
        len_d     = len_clamped;
        div_d     = divider;
        msb_d     = msb_first;
        rpt_d     = repeat_mode;
        per_cnt_d = '0;
        bit_idx_d = '0;
      end
    end else begin
      if (last_cycle) begin
        per_cnt_d = '0;
        bit_idx_d = '0;
        // A stop landing on the final cycle still completes the frame normally.
        if (!(rpt_q && !stop)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else if (stop) begin
        state_d   = ST_IDLE;
        per_cnt_d = '0;
        bit_idx_d = '0;
      end else if (bit_end) begin
        per_cnt_d = '0;
        bit_idx_d = bit_idx_q + LEN_W'(1);
      end else begin
        per_cnt_d = per_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      len_q     <= '0;
      div_q     <= '0;
      msb_q     <= 1'b0;
      rpt_q     <= 1'b0;
      per_cnt_q <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      div_q     <= div_d;
      msb_q     <= msb_d;
      rpt_q     <= rpt_d;
      per_cnt_q <= per_cnt_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign out       = busy && (|(data_q & (DATA_W'(1) << sel)));
  assign done      = done_q;
  assign bit_index = bit_idx_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: a frame-list reference model pushes
// expected per-cycle outputs; a monitor pops and compares them on the falling edge.
module tb_pattern_serializer;

  logic        clock;
  logic        reset_i;
  logic [31:0] data_i;
  logic [5:0]  length_i;
  logic [15:0] divider_i;
  logic        msb_i;
  logic        rpt_i;
  logic        start_i;
  logic        stop_i;
  logic        out_o;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  bit_index_o;

  pattern_serializer #(.DATA_W(32), .LEN_W(6), .DIV_W(16)) dut (
    .clock      (clock),
    .reset      (reset_i),
    .data       (data_i),
    .length     (length_i),
    .divider    (divider_i),
    .msb_first  (msb_i),
    .repeat_mode(rpt_i),
    .start      (start_i),
    .stop       (stop_i),
    .out        (out_o),
    .busy       (busy_o),
    .done       (done_o),
    .bit_index  (bit_index_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       done;
    logic       busy;
    logic       out;
    logic [5:0] idx;
  } obs_t;

  // One entry per clock of a frame: {bit value, bit index}.
  typedef logic [6:0] cyc_t;

  obs_t exp_q[$];
  cyc_t tmpl_q[$];
  cyc_t cur_q[$];
  logic m_rpt;

  int vectors;
  int miscompares;

  function automatic void build_frame();
    int len;
    logic b;
    len = (int'(length_i) > 32) ? 32 : int'(length_i);
    tmpl_q.delete();
    for (int k = 0; k < len; k++) begin
      b = msb_i ? data_i[len-1-k] : data_i[k];
      for (int p = 0; p <= int'(divider_i); p++) tmpl_q.push_back({b, 6'(k)});
    end
    m_rpt = rpt_i;
  endfunction

  function automatic void model_update();
    logic m_done;
    obs_t o;
    cyc_t f;
    m_done = 1'b0;
    if (reset_i) begin
      cur_q.delete();
    end else if (cur_q.size() != 0) begin
      void'(cur_q.pop_front());
      if (cur_q.size() == 0) begin
        if (m_rpt && !stop_i) cur_q = tmpl_q;
        else m_done = 1'b1;
      end else if (stop_i) begin
        cur_q.delete();
      end
    end else if (start_i && !stop_i && length_i != 6'd0) begin
      build_frame();
      cur_q = tmpl_q;
    end
    o = '0;
    o.done = m_done;
    if (cur_q.size() != 0) begin
      f = cur_q[0];
      o.busy = 1'b1;
      o.out  = f[6];
      o.idx  = f[5:0];
    end
    exp_q.push_back(o);
  endfunction

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic launch(input logic [31:0] d, input logic [5:0] len,
                        input logic [15:0] dv, input logic msb, input logic rpt);
    data_i    = d;
    length_i  = len;
    divider_i = dv;
    msb_i     = msb;
    rpt_i     = rpt;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {done_o, busy_o, out_o, bit_index_o};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t actual done=%b busy=%b out=%b idx=%0d required done=%b busy=%b out=%b idx=%0d",
                   $time, a.done, a.busy, a.out, a.idx, e.done, e.busy, e.out, e.idx);
        end
      end
    end
  end

  initial begin
    int waited;
    vectors     = 0;
    miscompares = 0;
    m_rpt       = 1'b0;
    reset_i     = 1'b1;
    data_i      = '0;
    length_i    = '0;
    divider_i   = '0;
    msb_i       = 1'b0;
    rpt_i       = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    idle(3);
    vectors++;
    if ({done_o, busy_o, out_o, bit_index_o} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_state t=%0t actual done=%b busy=%b out=%b idx=%0d required all zero",
               $time, done_o, busy_o, out_o, bit_index_o);
    end
    reset_i = 1'b0;
    idle(2);

    // Basic LSB-first, then MSB-first with divider
    launch(32'h0000_0006, 6'd4, 16'd0, 1'b0, 1'b0);
    idle(6);
    launch(32'h0000_0007, 6'd4, 16'd2, 1'b1, 1'b0);
    idle(15);

    // Repeat, then stop mid-bit
    launch(32'h0000_0005, 6'd3, 16'd1, 1'b0, 1'b1);
    idle(9);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    idle(3);

    // Repeat with stop on the exact final cycle completes normally
    launch(32'h0000_0002, 6'd2, 16'd0, 1'b1, 1'b1);
    step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    idle(3);

    // length=0 ignored; length=40 clamps to 32
    launch(32'hDEAD_BEEF, 6'd0, 16'd0, 1'b0, 1'b0);
    idle(3);
    launch(32'hA5C3_0F96, 6'd40, 16'd0, 1'b1, 1'b0);
    idle(35);

    // start and stop together in IDLE: nothing starts
    stop_i = 1'b1;
    launch(32'hFFFF_FFFF, 6'd4, 16'd0, 1'b0, 1'b0);
    stop_i = 1'b0;
    idle(3);

    // start while busy is ignored
    launch(32'h0000_00B4, 6'd8, 16'd1, 1'b0, 1'b0);
    idle(3);
    launch(32'hFFFF_FFFF, 6'd3, 16'd0, 1'b1, 1'b1);
    idle(20);

    // Back-to-back with start held high
    data_i = 32'h0000_0001; length_i = 6'd2; divider_i = 16'd0;
    msb_i = 1'b0; rpt_i = 1'b0; start_i = 1'b1;
    idle(7);
    start_i = 1'b0;
    idle(3);

    // Reset mid-frame, then a fresh frame
    launch(32'h1234_5678, 6'd32, 16'd0, 1'b0, 1'b0);
    idle(5);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    idle(2);
    launch(32'h0000_0006, 6'd4, 16'd0, 1'b0, 1'b0);
    idle(6);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      data_i    = $urandom;
      length_i  = 6'($urandom_range(0, 40));
      divider_i = 16'($urandom_range(0, 3));
      msb_i     = 1'($urandom_range(0, 1));
      rpt_i     = ($urandom_range(0, 3) == 0);
      start_i   = ($urandom_range(0, 2) == 0);
      stop_i    = ($urandom_range(0, 19) == 0);
      reset_i   = ($urandom_range(0, 499) == 0);
      step();
    end
    start_i = 1'b0; stop_i = 1'b0; reset_i = 1'b0; rpt_i = 1'b0;
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    idle(3);

    // Maximum divider: one bit held for 2^16 cycles
    launch(32'h0000_0001, 6'd1, 16'hFFFF, 1'b0, 1'b0);
    waited = 0;
    while (!done_o && waited < 65540) begin
      step();
      waited++;
    end
    vectors++;
    if (done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_done t=%0t done not seen within %0d cycles", $time, waited);
    end
    idle(3);

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
